// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word on a load/ready
// handshake and streams it out one bit per clock, with gapless back-to-back words.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pin,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               last_bit;
    logic               accept;

    // Moves the next bit into the output position; the vacated end fills with 0.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        last_bit   = (state_q == SHIFT) && (cnt_q == CNT_ONE);
        ready      = (state_q == IDLE) || last_bit;
        accept     = load && ready;
        sout_valid = (state_q == SHIFT);
        done       = last_bit;
        // The bit on sout comes straight from the register; it is all-zero in IDLE.
        sout       = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_FULL;
                    sh_d    = pin;
                end else begin
                    cnt_d = '0;
                    sh_d  = '0;
                end
            end
            SHIFT: begin
                if (accept) begin
                    cnt_d = CNT_FULL;
                    sh_d  = pin;
                end else if (last_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sh_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    sh_d  = advance(sh_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end
        endcase
    end

endmodule
